// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default link timing.
// The transmitter uses the same constants so both ends of the link agree.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Default clk cycles per serial bit (must be >= 4 and even).
  localparam int UART_CLKS_PER_BIT = 16;
  // Default data bits per frame (5..8), sent LSB first.
  localparam int UART_DATA_BITS    = 8;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: the raw serial line in, the byte stream and status out.
//
// Handshake: data_valid is a one-cycle strobe with no ready/backpressure.
// data_out is stable from the data_valid cycle until the next good frame,
// so a consumer must capture the byte on (or after) the strobe cycle.
// frame_err is an independent one-cycle strobe and never coincides with
// data_valid. state is the receiver FSM state, exported for debug/checkers.
interface uart_rx_if #(
  parameter int DATA_BITS = uart_pkg::UART_DATA_BITS
);
  import uart_pkg::*;

  logic                 rx;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 frame_err;
  logic                 busy;
  uart_state_e          state;

  // Receiver side: consumes the line, produces bytes and status.
  modport master (
    input  rx,
    output data_out, data_valid, frame_err, busy, state
  );

  // Line driver / byte consumer side.
  modport slave (
    output rx,
    input  data_out, data_valid, frame_err, busy, state
  );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input. The reset value
// is a parameter so idle-high lines (UART rx) and idle-low inputs (buttons)
// both come out of reset at their inactive level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; only sync_q is safe to use in the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1-style asynchronous serial receiver. The line is synchronized, the
// start bit is confirmed at its midpoint, and every following bit is then
// sampled one full bit period later, i.e. also at mid-bit. Returning to
// IDLE at the middle of the stop bit leaves half a bit of slack so a
// back-to-back start edge is never missed.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_rx_if.master bus
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = $clog2(DATA_BITS);

  // Terminal counts: a full bit period, half a bit, and the last data bit.
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  uart_state_e          state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.rx),
    .q_o   (rx_s)
  );

  // State, counters, shift register and registered output strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic; the baud counter restarts from 0 on every state entry.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!rx_s) begin
          state_d = START;
        end
      end

      START: begin
        if (baud_q == BAUD_HALF) begin
          baud_d = '0;
          if (rx_s) begin
            // Line went back high before mid-start: treat as a glitch.
            state_d = IDLE;
          end else begin
            state_d = DATA;
            idx_d   = '0;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d         = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = IDLE;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        baud_d  = '0;
      end
    endcase
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.state      = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a table of single frames (good and bad stop
// bits) plus hand-written sequences for reset, back-to-back frames, a start
// glitch and a reset in the middle of a frame.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int C = 16;
  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_if #(.DATA_BITS(W)) bus ();

  uart_rx #(
    .CLKS_PER_BIT (C),
    .DATA_BITS    (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_byte;
  int n_cmp = 0;
  int n_fail = 0;
  int valid_cnt = 0;
  int ferr_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.data_valid || bus.frame_err)
        check("valid_ferr_exclusive", {31'd0, bus.data_valid & bus.frame_err}, 32'd0);
      if (bus.data_valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_valid", {24'd0, bus.data_out}, 32'hFFFF_FFFF);
        end else begin
          exp_byte = exp_q.pop_front();
          check("sb_data", {24'd0, bus.data_out}, {24'd0, exp_byte});
        end
      end
      if (bus.frame_err) ferr_cnt++;
    end
  end

  // Global time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic send_bit(input logic b);
    bus.rx = b;
    repeat (C) @(negedge clk);
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < W; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [W-1:0] data;
    logic         stop;
    int           exp_valid;
    int           exp_ferr;
    logic [W-1:0] exp_out;
  } vec_t;

  vec_t vecs[6];

  int v0, f0, busy_cyc;

  initial begin
    vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_valid: 1, exp_ferr: 0, exp_out: 8'hA5};
    vecs[1] = '{data: 8'h01, stop: 1'b1, exp_valid: 1, exp_ferr: 0, exp_out: 8'h01};
    vecs[2] = '{data: 8'h80, stop: 1'b1, exp_valid: 1, exp_ferr: 0, exp_out: 8'h80};
    vecs[3] = '{data: 8'h7E, stop: 1'b0, exp_valid: 0, exp_ferr: 1, exp_out: 8'h80};
    vecs[4] = '{data: 8'h5A, stop: 1'b1, exp_valid: 1, exp_ferr: 0, exp_out: 8'h5A};
    vecs[5] = '{data: 8'hFF, stop: 1'b1, exp_valid: 1, exp_ferr: 0, exp_out: 8'hFF};

    // ---- reset held with rx toggling ----
    bus.rx = 1'b1;
    rst_n  = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      bus.rx = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("rst_data_out", {24'd0, bus.data_out}, 32'd0);
      check("rst_data_valid", {31'd0, bus.data_valid}, 32'd0);
      check("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
    end
    check("rst_state", {30'd0, bus.state}, {30'd0, IDLE});
    bus.rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(10);

    // ---- table of isolated frames ----
    for (int i = 0; i < 6; i++) begin
      v0 = valid_cnt;
      f0 = ferr_cnt;
      if (vecs[i].exp_valid == 1) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop);
      idle(24);
      check($sformatf("vec%0d_valid_cnt", i), valid_cnt - v0, vecs[i].exp_valid);
      check($sformatf("vec%0d_ferr_cnt", i), ferr_cnt - f0, vecs[i].exp_ferr);
      check($sformatf("vec%0d_data_out", i), {24'd0, bus.data_out}, {24'd0, vecs[i].exp_out});
      check($sformatf("vec%0d_busy", i), {31'd0, bus.busy}, 32'd0);
    end

    // ---- back-to-back frames, zero idle gap ----
    v0 = valid_cnt;
    f0 = ferr_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h3C);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle(24);
    check("b2b_valid_cnt", valid_cnt - v0, 32'd3);
    check("b2b_ferr_cnt", ferr_cnt - f0, 32'd0);
    check("b2b_data_out", {24'd0, bus.data_out}, 32'h3C);
    check("b2b_queue_empty", exp_q.size(), 32'd0);

    // ---- start glitch: 4 clk low then high ----
    v0 = valid_cnt;
    f0 = ferr_cnt;
    busy_cyc = 0;
    bus.rx = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.busy) busy_cyc++;
    end
    bus.rx = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (bus.busy) busy_cyc++;
    end
    check("glitch_busy_seen", {31'd0, (busy_cyc >= 1)}, 32'd1);
    check("glitch_busy_le8", {31'd0, (busy_cyc <= 8)}, 32'd1);
    check("glitch_valid_cnt", valid_cnt - v0, 32'd0);
    check("glitch_ferr_cnt", ferr_cnt - f0, 32'd0);
    check("glitch_state", {30'd0, bus.state}, {30'd0, IDLE});

    // ---- framing error keeps previous data ----
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_frame(8'h55, 1'b0);
    idle(24);
    check("ferr_valid_cnt", valid_cnt - v0, 32'd0);
    check("ferr_ferr_cnt", ferr_cnt - f0, 32'd1);
    check("ferr_data_out", {24'd0, bus.data_out}, 32'h3C);

    // ---- reset mid-frame, then a fresh frame ----
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'hC3 >> i));
    bus.rx = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_data_out", {24'd0, bus.data_out}, 32'd0);
    rst_n = 1'b1;
    idle(2 * C);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    idle(24);
    check("midrst_valid_cnt", valid_cnt - v0, 32'd1);
    check("midrst_ferr_cnt", ferr_cnt - f0, 32'd0);
    check("midrst_data_out_after", {24'd0, bus.data_out}, 32'h81);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
